// File: rtl/wdata_chan_rcvr_pkg.sv
// rtl/wdata_chan_rcvr_pkg.sv - shared write-data channel encodings and burst geometry
package wdata_chan_rcvr_pkg;

    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = 32;
    localparam int DATA_W    = BURST_LEN * BEAT_W;
    localparam int ID_W      = 4;
    localparam int CNT_W     = 2;

    // Receiver control states; the unused code 2'b11 recovers to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_HOLD = 2'b10
    } wchan_state_t;

endpackage

// File: rtl/wdata_chan_rcvr.sv
// rtl/wdata_chan_rcvr.sv - collects one 4-beat write-data burst into a 128-bit word
module wdata_chan_rcvr
    import wdata_chan_rcvr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wvalid,
    output logic              wready,
    input  logic [BEAT_W-1:0] wdata,
    input  logic              wlast,
    input  logic              start_rq,
    input  logic [ID_W-1:0]   start_id,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [DATA_W-1:0] out_wdata,
    output logic [ID_W-1:0]   out_id,
    output logic              out_err
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    wchan_state_t     state;
    wchan_state_t     state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             load_start;
    logic             accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the load/accept strobes that steer the datapath
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rq) begin
                    load_start = 1'b1;
                    state_nxt  = ST_RECV;
                end
            end
            ST_RECV: begin
                accept = wvalid;
                // Burst length is fixed: the fourth beat ends collection whatever wlast says
                if (wvalid && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ack) begin
                    if (start_rq) begin
                        load_start = 1'b1;
                        state_nxt  = ST_RECV;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wready    = (state == ST_RECV);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    // Burst datapath: id/error capture at start, beat placement and wlast checking per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            out_wdata <= '0;
            out_id    <= '0;
            out_err   <= 1'b0;
        end else if (load_start) begin
            beat_cnt <= '0;
            out_id   <= start_id;
            out_err  <= 1'b0;
        end else if (accept) begin
            out_wdata[int'(beat_cnt) * BEAT_W +: BEAT_W] <= wdata;
            beat_cnt <= beat_cnt + 1'b1;
            // wlast must appear on the final beat and nowhere else; error stays until next start
            if (wlast != (beat_cnt == LAST_BEAT)) begin
                out_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wdata_chan_rcvr.sv
// tb/tb_wdata_chan_rcvr.sv - self-checking bench for wdata_chan_rcvr
`timescale 1ns/1ps
module tb_wdata_chan_rcvr;

    logic         clk;
    logic         rst_n;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         start_rq;
    logic [3:0]   start_id;
    logic         busy;
    logic         out_valid;
    logic         out_ack;
    logic [127:0] out_wdata;
    logic [3:0]   out_id;
    logic         out_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] REF_DATA = 128'h44444444_33333333_22222222_11111111;

    wdata_chan_rcvr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wlast     (wlast),
        .start_rq  (start_rq),
        .start_id  (start_id),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_wdata (out_wdata),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Feeds beats from cycle 1 onwards; st holds stall cycles inserted before each beat
    task automatic feed(input logic [127:0] d, input logic [3:0] l, input logic [7:0] st,
                        input int pulse_cyc, output int cyc);
        int k;
        int stall_left;
        k = 0;
        stall_left = int'(st[1:0]);
        cyc = 1;
        while (cyc < 60 && !out_valid) begin
            if (k < 4 && wready) begin
                if (stall_left > 0) begin
                    wvalid = 1'b0;
                    stall_left--;
                end else begin
                    wvalid = 1'b1;
                    wdata  = d[k*32 +: 32];
                    wlast  = l[k];
                    k++;
                    if (k < 4) stall_left = int'(st[k*2 +: 2]);
                end
            end else begin
                wvalid = 1'b0;
            end
            if (cyc == pulse_cyc) begin
                start_rq = 1'b1;
                start_id = 4'h3;
            end else begin
                start_rq = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0; start_rq = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL feed_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [127:0] d, input logic [3:0] l,
                             input logic [7:0] st, input int pulse_cyc, output int cyc);
        start_rq = 1'b1; start_id = id; wvalid = 1'b0;
        @(posedge clk); #1;
        start_rq = 1'b0;
        feed(d, l, st, pulse_cyc, cyc);
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wvalid = 0; wdata = 0; wlast = 0; start_rq = 0; start_id = 0; out_ack = 0;
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if ({wready, out_valid, busy, out_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: wready/valid/busy/err=%b required 0000", {wready, out_valid, busy, out_err});
        end
        n_tests++;
        if (out_wdata !== 128'h0 || out_id !== 4'h0) begin
            n_fail++; $display("FAIL reset_data: out_wdata=%h out_id=%h required 0/0", out_wdata, out_id);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_ack();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        int cyc;
        run_burst(4'h5, REF_DATA, 4'b1000, 8'h00, -1, cyc);
        n_tests++;
        if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: out_valid at cycle %0d required 5", cyc); end
        n_tests++;
        if (out_wdata !== REF_DATA) begin n_fail++; $display("FAIL basic_data: %h required %h", out_wdata, REF_DATA); end
        n_tests++;
        if (out_id !== 4'h5 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_id_err: id=%h err=%b required 5/0", out_id, out_err);
        end
        n_tests++;
        if (wready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_hold_flags: wready=%b busy=%b required 0/1", wready, busy);
        end
        do_ack();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack_idle: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_stall();
        int cyc;
        run_burst(4'h5, REF_DATA, 4'b1000, 8'h20, -1, cyc);
        n_tests++;
        if (cyc !== 7) begin n_fail++; $display("FAIL stall_latency: out_valid at cycle %0d required 7", cyc); end
        n_tests++;
        if (out_wdata !== REF_DATA || out_err !== 1'b0) begin
            n_fail++; $display("FAIL stall_data: %h err=%b required %h err=0", out_wdata, out_err, REF_DATA);
        end
        do_ack();
    endtask

    task automatic test_wlast_err();
        int cyc;
        run_burst(4'h1, REF_DATA, 4'b0010, 8'h00, -1, cyc);
        n_tests++;
        if (cyc !== 5 || out_wdata !== REF_DATA) begin
            n_fail++; $display("FAIL early_wlast_beats: cycle %0d data %h required 5 %h", cyc, out_wdata, REF_DATA);
        end
        n_tests++;
        if (out_err !== 1'b1) begin n_fail++; $display("FAIL early_wlast_err: err=%b required 1", out_err); end
        do_ack();
        run_burst(4'h2, REF_DATA, 4'b0000, 8'h00, -1, cyc);
        n_tests++;
        if (out_err !== 1'b1) begin n_fail++; $display("FAIL missing_wlast_err: err=%b required 1", out_err); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [127:0] d2;
        run_burst(4'h7, REF_DATA, 4'b0000, 8'h00, -1, cyc);
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || wready !== 1'b0 || out_wdata !== REF_DATA || out_id !== 4'h7) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b wready=%b data=%h id=%h required 1/0/%h/7",
                         out_valid, wready, out_wdata, out_id, REF_DATA);
            end
        end
        out_ack = 1'b1; start_rq = 1'b1; start_id = 4'hA;
        @(posedge clk); #1;
        out_ack = 1'b0; start_rq = 1'b0;
        n_tests++;
        if (wready !== 1'b1 || out_valid !== 1'b0 || out_id !== 4'hA || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: wready=%b valid=%b id=%h err=%b required 1/0/A/0",
                     wready, out_valid, out_id, out_err);
        end
        d2 = {$urandom, $urandom, $urandom, $urandom};
        feed(d2, 4'b1000, 8'h00, -1, cyc);
        n_tests++;
        if (out_wdata !== d2 || out_err !== 1'b0 || cyc !== 5) begin
            n_fail++; $display("FAIL b2b_data: %h err=%b cycle %0d required %h err=0 cycle 5", out_wdata, out_err, cyc, d2);
        end
        do_ack();
    endtask

    task automatic test_start_ignored();
        int cyc;
        run_burst(4'h9, REF_DATA, 4'b1000, 8'h04, 2, cyc);
        n_tests++;
        if (out_id !== 4'h9 || out_wdata !== REF_DATA || cyc !== 6) begin
            n_fail++; $display("FAIL recv_start_ignored: id=%h data=%h cycle %0d required 9 %h 6", out_id, out_wdata, cyc, REF_DATA);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_rq = 1'b1; start_id = 4'hC;
        @(posedge clk); #1;
        start_rq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'hDEAD0000 + 32'(i); wlast = 1'b0;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (wready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_wdata !== 128'h0 || out_id !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: wready=%b busy=%b valid=%b data=%h id=%h required 0/0/0/0/0",
                     wready, busy, out_valid, out_wdata, out_id);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(4'h6, REF_DATA, 4'b1000, 8'h00, -1, cyc);
        n_tests++;
        if (out_wdata !== REF_DATA || out_id !== 4'h6 || out_err !== 1'b0 || cyc !== 5) begin
            n_fail++; $display("FAIL reset_recover: data=%h id=%h err=%b cycle %0d required %h 6 0 5", out_wdata, out_id, out_err, cyc, REF_DATA);
        end
        do_ack();
    endtask

    task automatic test_random();
        int cyc;
        int exp_cyc;
        logic [127:0] d;
        logic [3:0] l;
        logic [7:0] st;
        logic [3:0] id;
        logic exp_err;
        for (int it = 0; it < 24; it++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            l  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1000;
            st = 8'($urandom);
            id = 4'($urandom);
            exp_err = (l != 4'b1000);
            exp_cyc = 5 + int'(st[1:0]) + int'(st[3:2]) + int'(st[5:4]) + int'(st[7:6]);
            run_burst(id, d, l, st, -1, cyc);
            n_tests++;
            if (out_wdata !== d || out_id !== id || out_err !== exp_err || cyc !== exp_cyc) begin
                n_fail++;
                $display("FAIL random_%0d: data=%h id=%h err=%b cycle %0d required %h %h %b %0d",
                         it, out_wdata, out_id, out_err, cyc, d, id, exp_err, exp_cyc);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wlast_err();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wdata_chan_rcvr.md
WDATA_CHAN_RCVR -- requirements
Module: wdata_chan_rcvr

Interface
REQ-001 Parameters: none; burst length fixed at 4 beats of 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wvalid  input  1  write-data beat valid from bus initiator.
REQ-005 wready  output  1  receiver ready to accept a beat.
REQ-006 wdata  input  32  write-data beat.
REQ-007 wlast  input  1  initiator's last-beat marker.
REQ-008 start_rq  input  1  one-cycle pulse: address accepted, begin receiving one burst.
REQ-009 start_id  input  4  transaction id, sampled with start_rq.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 out_valid  output  1  assembled 128-bit write data available.
REQ-012 out_ack  input  1  consumer accepts assembled data.
REQ-013 out_wdata  output  128  assembled burst data.
REQ-014 out_id  output  4  id of the assembled burst.
REQ-015 out_err  output  1  wlast protocol error seen in this burst.

Function
REQ-016 State machine SHALL have states IDLE=2'b00, RECV=2'b01, HOLD=2'b10; code 2'b11 SHALL return to IDLE on the next edge.
REQ-017 IDLE: start_rq=1 -> RECV; start_id latched into out_id, beat counter cleared to 0, out_err cleared; start_rq=0 -> stay.
REQ-018 start_rq SHALL be ignored in RECV, and in HOLD unless out_ack=1 in the same cycle.
REQ-019 wready SHALL equal (state==RECV), combinationally from state only, never from wvalid.
REQ-020 Beat accepted when wvalid & wready; beat n (counter 0..3) SHALL be written to out_wdata[32n+31:32n], beat 0 lowest.
REQ-021 Counter: 2 bits, increments by 1 per accepted beat, wraps 3->0; no change on cycles without acceptance.
REQ-022 Error: out_err SHALL be set (sticky until next burst start) if wlast=1 on an accepted beat 0..2, or wlast=0 on accepted beat 3.
REQ-023 RECV -> HOLD on the cycle after beat 3 is accepted, regardless of wlast; a wlast-early burst still collects exactly 4 beats.
REQ-024 HOLD: out_valid=1, wready=0; out_wdata, out_id, out_err SHALL stay stable until out_ack.
REQ-025 HOLD with out_ack=1, start_rq=0 -> IDLE; out_ack=1, start_rq=1 -> RECV with new id latched, counter and out_err cleared (back-to-back).
REQ-026 out_valid SHALL equal (state==HOLD); out_ack outside HOLD SHALL be ignored.
REQ-027 Latency: start_rq in cycle 0 with wvalid held high from cycle 1 -> beats accepted cycles 1..4, out_valid high from cycle 5.
REQ-028 wvalid stalls in RECV SHALL hold counter and data; no timeout.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, counter=0, out_wdata=0, out_id=0, out_err=0; thus wready=0, out_valid=0, busy=0.
REQ-030 Reset mid-burst SHALL discard partial data; no out_valid is produced for that burst.

Structure
REQ-031 Shared package SHALL hold the state encodings, burst length (4) and beat width (32), shared with the write-data transmitter side.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 start_rq, start_id=4'h5; beats 32'h11111111, 22222222, 33333333, 44444444 with wlast on beat 4 -> out_wdata=128'h44444444_33333333_22222222_11111111, out_id=5, out_err=0, out_valid at cycle 5.
REQ-034 Same burst with wvalid low 2 cycles between beats 2 and 3 -> identical data, out_valid at cycle 7.
REQ-035 wlast=1 on beat 2 -> still 4 beats collected, out_err=1; wlast never asserted -> out_err=1.
REQ-036 out_ack held low 3 cycles in HOLD -> out_valid and out_wdata stable, wready=0; then out_ack with start_rq, start_id=4'hA -> RECV next cycle, out_id=A, out_err=0.
REQ-037 rst_n low after beat 2 -> wready=0, busy=0, out_wdata=0 immediately; new burst after release assembles correctly.
REQ-038 start_rq pulsed during RECV with start_id=4'h3 -> ignored; out_id keeps original value.
